// File: rtl/core_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pipe_ctrl_pkg
//  Purpose  : Shared types and constants for the xRV32I pipeline controller
//             (state encodings, bus widths, zero register).
//  Revision : 1.0  initial release
// ============================================================================
package core_pipe_ctrl_pkg;

   // Controller state width and encodings; the fourth code is unused.
   localparam int c_pipe_state_w = 2;

   typedef enum logic [c_pipe_state_w-1:0] {
      PIPE_RUN     = 2'd0,
      PIPE_FLUSH   = 2'd1,
      PIPE_MEMWAIT = 2'd2
   } pipe_state_e;

   // Instruction address bus and register index widths shared with the core.
   localparam int c_inst_addr_w = 32;
   localparam int c_reg_w       = 5;

   // x0 is hard-wired to zero, so writes to it never create a dependency.
   localparam logic [c_reg_w-1:0] c_zero_reg = 5'd0;

endpackage : core_pipe_ctrl_pkg
`default_nettype wire

// File: rtl/core_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : core_hazard_detect
//  Purpose  : Combinational load-use hazard detection between the instruction
//             in ID and a load in EX.
//  Revision : 1.0  initial release
// ============================================================================
module core_hazard_detect
   import core_pipe_ctrl_pkg::*;
(
   input  logic [c_reg_w-1:0] id_rs1_i,
   input  logic [c_reg_w-1:0] id_rs2_i,
   input  logic               id_rs1_used_i,
   input  logic               id_rs2_used_i,
   input  logic [c_reg_w-1:0] ex_rd_i,
   input  logic               ex_reg_we_i,
   input  logic               ex_is_load_i,
   output logic               load_use_o
);

   logic ex_load_writes;
   logic rs1_hit;
   logic rs2_hit;

   // A load result is only available after MEM, so any real consumer in ID must wait.
   always_comb begin
      ex_load_writes = ex_is_load_i & ex_reg_we_i & (ex_rd_i != c_zero_reg);
      rs1_hit        = id_rs1_used_i & (id_rs1_i == ex_rd_i);
      rs2_hit        = id_rs2_used_i & (id_rs2_i == ex_rd_i);
      load_use_o     = ex_load_writes & (rs1_hit | rs2_hit);
   end

endmodule : core_hazard_detect
`default_nettype wire

// File: rtl/core_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : core_pipe_ctrl
//  Purpose  : Pipeline sequencing controller: load-use stalls, jump flushes,
//             data-memory wait stalls with timeout, and perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module core_pipe_ctrl
   import core_pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_WIDTH    = 32
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [c_reg_w-1:0]        id_rs1_i,
   input  logic [c_reg_w-1:0]        id_rs2_i,
   input  logic                      id_rs1_used_i,
   input  logic                      id_rs2_used_i,
   input  logic [c_reg_w-1:0]        ex_rd_i,
   input  logic                      ex_reg_we_i,
   input  logic                      ex_is_load_i,
   input  logic                      ex_jump_en_i,
   input  logic [c_inst_addr_w-1:0]  ex_jump_addr_i,
   input  logic                      mem_req_i,
   input  logic                      mem_ack_i,
   output logic                      hold_pc_o,
   output logic                      hold_if_id_o,
   output logic                      hold_id_ex_o,
   output logic                      flush_if_id_o,
   output logic                      flush_id_ex_o,
   output logic                      jump_en_o,
   output logic [c_inst_addr_w-1:0]  jump_addr_o,
   output logic                      mem_timeout_o,
   output logic [c_pipe_state_w-1:0] state_o,
   output logic [CNT_WIDTH-1:0]      stall_cnt_o,
   output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

   // Flush counter holds FLUSH_CYCLES-1; wait counter counts up to MEM_WAIT_MAX.
   localparam int c_fcnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int c_wcnt_w = $clog2(MEM_WAIT_MAX + 1);

   localparam logic [c_fcnt_w-1:0] c_flush_init = c_fcnt_w'(FLUSH_CYCLES - 1);
   localparam logic [c_fcnt_w-1:0] c_flush_one  = c_fcnt_w'(1);
   localparam logic [c_wcnt_w-1:0] c_wait_max   = c_wcnt_w'(MEM_WAIT_MAX);
   localparam logic [c_wcnt_w-1:0] c_wait_one   = c_wcnt_w'(1);

   pipe_state_e          state_q, state_d;
   logic [c_fcnt_w-1:0]  fcnt_q, fcnt_d;
   logic [c_wcnt_w-1:0]  wcnt_q, wcnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic hold_pc;
   logic hold_if_id;
   logic hold_id_ex;
   logic flush_if_id;
   logic flush_id_ex;
   logic jump_en;
   logic mem_timeout;

   core_hazard_detect u_hazard (
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .ex_rd_i       (ex_rd_i),
      .ex_reg_we_i   (ex_reg_we_i),
      .ex_is_load_i  (ex_is_load_i),
      .load_use_o    (load_use)
   );

   // Next-state and control decode; memory wait beats jump beats load-use in RUN.
   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      wcnt_d      = wcnt_q;
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_en     = 1'b0;
      mem_timeout = 1'b0;
      case (state_q)
         PIPE_RUN: begin
            if (mem_req_i && !mem_ack_i) begin
               hold_pc    = 1'b1;
               hold_if_id = 1'b1;
               hold_id_ex = 1'b1;
               state_d    = PIPE_MEMWAIT;
               wcnt_d     = c_wait_one;
            end else if (ex_jump_en_i) begin
               jump_en     = 1'b1;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = PIPE_FLUSH;
                  fcnt_d  = c_flush_init;
               end
            end else if (load_use) begin
               hold_pc     = 1'b1;
               hold_if_id  = 1'b1;
               flush_id_ex = 1'b1;
            end
         end
         PIPE_FLUSH: begin
            // Wrong-path instructions: every request is ignored here.
            flush_if_id = 1'b1;
            fcnt_d      = fcnt_q - c_flush_one;
            if (fcnt_q <= c_flush_one) begin
               state_d = PIPE_RUN;
            end
         end
         PIPE_MEMWAIT: begin
            if (mem_ack_i) begin
               state_d = PIPE_RUN;
            end else if (wcnt_q == c_wait_max) begin
               mem_timeout = 1'b1;
               state_d     = PIPE_RUN;
            end else begin
               hold_pc    = 1'b1;
               hold_if_id = 1'b1;
               hold_id_ex = 1'b1;
               wcnt_d     = wcnt_q + c_wait_one;
            end
         end
         default: begin
            state_d = PIPE_RUN;
         end
      endcase
   end

   // Performance counters wrap naturally at 2^CNT_WIDTH.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hold_pc) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if (jump_en) begin
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   // State and counter registers; reset abandons any flush or memory wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PIPE_RUN;
         fcnt_q      <= '0;
         wcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Controls are forced low while reset is asserted, whatever the inputs do.
   always_comb begin
      hold_pc_o     = rst_n & hold_pc;
      hold_if_id_o  = rst_n & hold_if_id;
      hold_id_ex_o  = rst_n & hold_id_ex;
      flush_if_id_o = rst_n & flush_if_id;
      flush_id_ex_o = rst_n & flush_id_ex;
      jump_en_o     = rst_n & jump_en;
      jump_addr_o   = (rst_n && jump_en) ? ex_jump_addr_i : '0;
      mem_timeout_o = rst_n & mem_timeout;
      state_o       = state_q;
      stall_cnt_o   = stall_cnt_q;
      flush_cnt_o   = flush_cnt_q;
   end

endmodule : core_pipe_ctrl
`default_nettype wire
